// File: rtl/program_chain_driver.sv
// Host-side driver for the fabric's serial configuration chain.
// Config words from the host are shifted MSB-first into the chain head.
// At the same time the bits leaving the chain tail are captured, so the
// old configuration is handed back to the host one word at a time.
module program_chain_driver #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 256
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [WORD_W-1:0] cfg_word_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  output logic [WORD_W-1:0] rdata_o,
  output logic              rdata_valid_o,
  input  logic              rdata_ready_i,
  output logic              program_en_o,
  output logic              program_data_o,
  input  logic              chain_data_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam int NUM_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = CHAIN_LEN - (NUM_WORDS - 1) * WORD_W;
  // The final capture is shifted up by this many bits so it reads left-aligned.
  localparam int PAD_BITS  = WORD_W - LAST_BITS;
  localparam int BIT_CNT_W = $clog2(WORD_W + 1);
  localparam int WORDS_W   = $clog2(NUM_WORDS + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DRAIN,
    ST_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [WORDS_W-1:0]    words_rem_q, words_rem_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0]     tx_q, tx_d;
  logic [WORD_W-1:0]     cap_q, cap_d;

  logic                  last_word;
  logic [WORD_W-1:0]     cap_shift;

  assign last_word = (words_rem_q == WORDS_W'(1));

  // Capture register advanced by one bit, taking the chain's tail bit at the LSB.
  always_comb begin
    cap_shift    = cap_q << 1;
    cap_shift[0] = chain_data_i;
  end

  // Next-state and datapath update for the load/shift/drain sequence.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    words_rem_d = words_rem_q;
    bit_cnt_d   = bit_cnt_q;
    tx_d        = tx_q;
    cap_d       = cap_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          words_rem_d = WORDS_W'(NUM_WORDS);
          state_d     = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (cfg_valid_i) begin
          tx_d      = cfg_word_i;
          cap_d     = '0;
          bit_cnt_d = last_word ? BIT_CNT_W'(LAST_BITS) : BIT_CNT_W'(WORD_W);
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        tx_d      = tx_q << 1;
        cap_d     = cap_shift;
        bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
        if (bit_cnt_q == BIT_CNT_W'(1)) begin
          state_d = ST_DRAIN;
          if (last_word) begin
            cap_d = cap_shift << PAD_BITS;
          end
        end
      end

      ST_DRAIN: begin
        if (rdata_ready_i) begin
          words_rem_d = words_rem_q - WORDS_W'(1);
          state_d     = last_word ? ST_DONE : ST_LOAD;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything so every output reads 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      words_rem_q <= '0;
      bit_cnt_q   <= '0;
      tx_q        <= '0;
      cap_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from pre-edge values.
      state_q     <= state_d;
      words_rem_q <= words_rem_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_q        <= tx_d;
      cap_q       <= cap_d;
    end
  end

  // Outputs are pure decodes of registered state; none depends on an input.
  assign cfg_ready_o    = (state_q == ST_LOAD);
  assign program_en_o   = (state_q == ST_SHIFT);
  assign program_data_o = program_en_o & tx_q[WORD_W-1];
  assign rdata_valid_o  = (state_q == ST_DRAIN);
  assign rdata_o        = rdata_valid_o ? cap_q : '0;
  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = (state_q == ST_DONE);

endmodule

// File: tb/tb_program_chain_driver.sv
// Directed bench for program_chain_driver with a 40-flop behavioural chain.
module tb_program_chain_driver;

  localparam int WORD_W    = 16;
  localparam int CHAIN_LEN = 40;
  localparam int TMO       = 200;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              start_i = 1'b0;
  logic [WORD_W-1:0] cfg_word_i = '0;
  logic              cfg_valid_i = 1'b0;
  logic              cfg_ready_o;
  logic [WORD_W-1:0] rdata_o;
  logic              rdata_valid_o;
  logic              rdata_ready_i = 1'b0;
  logic              program_en_o;
  logic              program_data_o;
  logic              chain_data_i;
  logic              busy_o;
  logic              done_o;

  program_chain_driver #(
    .WORD_W    (WORD_W),
    .CHAIN_LEN (CHAIN_LEN)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .cfg_word_i     (cfg_word_i),
    .cfg_valid_i    (cfg_valid_i),
    .cfg_ready_o    (cfg_ready_o),
    .rdata_o        (rdata_o),
    .rdata_valid_o  (rdata_valid_o),
    .rdata_ready_i  (rdata_ready_i),
    .program_en_o   (program_en_o),
    .program_data_o (program_data_o),
    .chain_data_i   (chain_data_i),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural chain: index 0 is the head flop, index 39 the tail.
  logic [CHAIN_LEN-1:0] chain = '0;
  logic                 preload_req = 1'b0;
  logic [CHAIN_LEN-1:0] preload_val = '0;
  assign chain_data_i = chain[CHAIN_LEN-1];

  always @(posedge clk_i) begin
    if (preload_req) chain <= preload_val;
    else if (program_en_o) chain <= {chain[CHAIN_LEN-2:0], program_data_o};
  end

  // Event counters sampled on the active edge.
  int en_cnt = 0, cfg_hs = 0, rd_hs = 0, done_cnt = 0;
  always @(posedge clk_i) begin
    if (program_en_o) en_cnt <= en_cnt + 1;
    if (cfg_valid_i && cfg_ready_o) cfg_hs <= cfg_hs + 1;
    if (rdata_valid_o && rdata_ready_i) rd_hs <= rd_hs + 1;
    if (done_o) done_cnt <= done_cnt + 1;
  end

  int errors = 0;
  int checks = 0;
  bit poke_start = 1'b0;

  task automatic send_word(input logic [WORD_W-1:0] w, input int gap);
    int n;
    for (int k = 0; k < gap; k++) begin
      checks++;
      if ({cfg_ready_o, program_en_o} !== 2'b10) begin
        errors++;
        $display("FAIL gap_wait: ready/en got %b expected 10", {cfg_ready_o, program_en_o});
      end
      @(negedge clk_i);
    end
    cfg_word_i  = w;
    cfg_valid_i = 1'b1;
    n = 0;
    while (cfg_ready_o !== 1'b1 && n < TMO) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= TMO) begin
      checks++;
      errors++;
      $display("FAIL cfg_ready_timeout: got %b expected 1", cfg_ready_o);
      cfg_valid_i = 1'b0;
      return;
    end
    @(negedge clk_i);
    cfg_valid_i = 1'b0;
    cfg_word_i  = '1;
    checks++;
    if (program_en_o !== 1'b1) begin
      errors++;
      $display("FAIL first_enable: got %b expected 1", program_en_o);
    end
    if (poke_start) begin
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
    end
  endtask

  task automatic recv_word(output logic [WORD_W-1:0] r, input int stall);
    int n;
    logic [WORD_W-1:0] snap;
    n = 0;
    r = '0;
    while (rdata_valid_o !== 1'b1 && n < TMO) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= TMO) begin
      checks++;
      errors++;
      $display("FAIL rdata_valid_timeout: got %b expected 1", rdata_valid_o);
      return;
    end
    snap = rdata_o;
    for (int k = 0; k < stall; k++) begin
      checks++;
      if (rdata_o !== snap || rdata_valid_o !== 1'b1 || program_en_o !== 1'b0 || cfg_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: rdata %h valid %b en %b ready %b expected %h 1 0 0",
                 rdata_o, rdata_valid_o, program_en_o, cfg_ready_o, snap);
      end
      start_i = (poke_start && k == 1);
      @(negedge clk_i);
    end
    start_i       = 1'b0;
    rdata_ready_i = 1'b1;
    r             = rdata_o;
    @(negedge clk_i);
    rdata_ready_i = 1'b0;
  endtask

  task automatic do_preload();
    preload_val = 40'hA5A5A5A5A5;
    preload_req = 1'b1;
    @(negedge clk_i);
    preload_req = 1'b0;
  endtask

  // Full three-word sequence with optional host gaps and readback stall on word 0.
  task automatic run_seq(input string name,
                         input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1,
                         input logic [WORD_W-1:0] w2, input int gap, input int stall,
                         input logic [CHAIN_LEN-1:0] exp_chain);
    logic [WORD_W-1:0] w[3];
    logic [WORD_W-1:0] r[3];
    logic [WORD_W-1:0] e[3];
    int b_en, b_cfg, b_rd, b_done;
    w[0] = w0; w[1] = w1; w[2] = w2;
    e[0] = 16'hA5A5; e[1] = 16'hA5A5; e[2] = 16'hA500;
    do_preload();
    b_en = en_cnt; b_cfg = cfg_hs; b_rd = rd_hs; b_done = done_cnt;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_word(w[i], gap);
      recv_word(r[i], (i == 0) ? stall : 0);
    end
    checks++;
    if ({done_o, busy_o} !== 2'b11) begin
      errors++;
      $display("FAIL %s done_pulse: done/busy got %b expected 11", name, {done_o, busy_o});
    end
    @(negedge clk_i);
    checks++;
    if ({done_o, busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL %s after_done: done/busy got %b expected 00", name, {done_o, busy_o});
    end
    checks++;
    if (en_cnt - b_en !== CHAIN_LEN) begin
      errors++;
      $display("FAIL %s enable_count: got %0d expected %0d", name, en_cnt - b_en, CHAIN_LEN);
    end
    checks++;
    if (chain !== exp_chain) begin
      errors++;
      $display("FAIL %s chain: got %h expected %h", name, chain, exp_chain);
    end
    checks++;
    if (cfg_hs - b_cfg !== 3 || rd_hs - b_rd !== 3) begin
      errors++;
      $display("FAIL %s handshakes: cfg %0d rd %0d expected 3 3", name, cfg_hs - b_cfg, rd_hs - b_rd);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (r[i] !== e[i]) begin
        errors++;
        $display("FAIL %s readback%0d: got %h expected %h", name, i, r[i], e[i]);
      end
    end
    repeat (3) @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0 || done_cnt - b_done !== 1) begin
      errors++;
      $display("FAIL %s idle_after: busy %b dones %0d expected 0 1", name, busy_o, done_cnt - b_done);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      start_i       = i[0];
      cfg_valid_i   = i[1];
      rdata_ready_i = ~i[0];
      cfg_word_i    = 16'h5A5A ^ WORD_W'(i);
      #1;
      checks++;
      if ({cfg_ready_o, rdata_valid_o, program_en_o, program_data_o, busy_o, done_o, rdata_o} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: en %b ready %b valid %b busy %b done %b rdata %h expected all 0",
                 program_en_o, cfg_ready_o, rdata_valid_o, busy_o, done_o, rdata_o);
      end
    end
    start_i = 1'b0; cfg_valid_i = 1'b0; rdata_ready_i = 1'b0; cfg_word_i = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_busy: got %b expected 0", busy_o);
    end
  endtask

  task automatic test_full_load();
    run_seq("full_load", 16'h1234, 16'h5678, 16'h9AFF, 0, 0, 40'h123456789A);
  endtask

  task automatic test_backpressure();
    run_seq("backpressure", 16'h1234, 16'h5678, 16'h9AFF, 0, 10, 40'h123456789A);
  endtask

  task automatic test_host_gaps();
    run_seq("host_gaps", 16'h1234, 16'h5678, 16'h9AFF, 5, 0, 40'h123456789A);
  endtask

  task automatic test_start_while_busy();
    poke_start = 1'b1;
    run_seq("start_busy", 16'hC0DE, 16'h0F0F, 16'h3CAB, 0, 3, 40'hC0DE0F0F3C);
    poke_start = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    logic [WORD_W-1:0] r;
    do_preload();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    send_word(16'h1111, 0);
    recv_word(r, 0);
    send_word(16'h2222, 0);
    repeat (4) @(negedge clk_i);
    checks++;
    if (program_en_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_shift_pre: en got %b expected 1", program_en_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({program_en_o, busy_o, cfg_ready_o, rdata_valid_o, program_data_o} !== 5'b0) begin
      errors++;
      $display("FAIL mid_shift_reset: en %b busy %b expected 0 0", program_en_o, busy_o);
    end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    run_seq("after_reset", 16'hDEAD, 16'hBEEF, 16'hC3FF, 0, 0, 40'hDEADBEEFC3);
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_backpressure();
    test_host_gaps();
    test_start_while_busy();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
